// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add unsigned multiplier.
// Retires one multiplier bit per BUSY cycle, taking WIDTH cycles regardless of operand values.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_a, r_b;
    logic [2*WIDTH-1:0]   r_acc, w_addend;
    logic                 w_bit, w_last, w_accept;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_bit     = |(r_b & (WIDTH'(1) << r_cnt));
    assign w_addend  = w_bit ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
    assign w_last    = r_cnt == CW'(WIDTH - 1);
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign product   = r_acc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? BUSY : IDLE;
            BUSY:    w_next = w_last ? DONE : BUSY;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // The accumulator doubles as the product register, so it holds its value through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_acc <= r_acc + w_addend;
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule
